sm4_round_engine: RTL and testbench

// Iterative, parametrised SM4 round engine: runs all 32 rounds on one 128-bit block, unrolled rounds_per_cycle_p per clock.

---
 rtl/sm4_round_engine_pkg.sv | 80 ++++++++
 rtl/sm4_round_engine_if.sv | 33 +++
 rtl/sm4_round_engine_round_comb.sv | 32 +++
 rtl/sm4_round_engine.sv | 106 ++++++++++
 tb/tb_sm4_round_engine.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/sm4_round_engine_pkg.sv
// rtl/sm4_round_engine_pkg.sv - SM4 constants, mode/state types and round helper functions
// Shared by the round engine, its interface and the single-round combinational slice.
package sm4_round_engine_pkg;

  localparam int group_size_p = 4;
  localparam int word_width_p = 32;
  localparam int byte_width_p = 8;

  typedef enum logic [1:0] {
    MODE_KEY = 2'd0,
    MODE_ENC = 2'd1,
    MODE_DEC = 2'd2
  } sm4_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } engine_state_e;

  localparam logic [31:0] FK [group_size_p] = '{32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC};
  localparam logic [127:0] FK_BLOCK = {FK[0], FK[1], FK[2], FK[3]};

  localparam logic [2047:0] SBOX_BITS = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  function automatic logic rounds_per_cycle_ok(input int rpc);
    return (rpc == 1) || (rpc == 2) || (rpc == 4) || (rpc == 8);
  endfunction

  // Entry 0 sits in the most significant byte of the table.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [10:0] base;
    base = 11'(2047 - 8 * int'(a));
    return SBOX_BITS[base -: 8];
  endfunction

  function automatic logic [31:0] rol32(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] l_enc(input logic [31:0] b);
    return b ^ rol32(b, 2) ^ rol32(b, 10) ^ rol32(b, 18) ^ rol32(b, 24);
  endfunction

  function automatic logic [31:0] l_key(input logic [31:0] b);
    return b ^ rol32(b, 13) ^ rol32(b, 23);
  endfunction

  // CK[i] byte j = (4i+j)*7 mod 256.
  function automatic logic [31:0] ck_word(input logic [4:0] idx);
    logic [31:0] w;
    w = '0;
    for (int j = 0; j < group_size_p; j++) begin
      w[31 - byte_width_p * j -: byte_width_p] = 8'((4 * int'(idx) + j) * 7);
    end
    return w;
  endfunction

  function automatic sm4_mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'd0:    return MODE_KEY;
      2'd2:    return MODE_DEC;
      default: return MODE_ENC;
    endcase
  endfunction

  function automatic logic [127:0] reverse_words(input logic [127:0] x);
    return {x[31:0], x[63:32], x[95:64], x[127:96]};
  endfunction

endpackage

// File: rtl/sm4_round_engine_if.sv
// rtl/sm4_round_engine_if.sv - request/result/key-store bundle of the SM4 round engine
// slave is the engine side, master the controller and key-store side.
interface sm4_round_engine_if
  import sm4_round_engine_pkg::*;
#(
  parameter int rounds_per_cycle_p = 1
);

  logic                                   v_i;
  logic                                   ready_o;
  logic [1:0]                             mode_i;
  logic [127:0]                           data_i;
  logic [4:0]                             rkey_addr_o;
  logic                                   rkey_decr_o;
  logic [word_width_p*rounds_per_cycle_p-1:0] rkey_i;
  logic                                   rk_v_o;
  logic [4:0]                             rk_idx_o;
  logic [word_width_p*rounds_per_cycle_p-1:0] rk_o;
  logic                                   v_o;
  logic [127:0]                           data_o;
  logic                                   yumi_i;

  modport slave (
    input  v_i, mode_i, data_i, rkey_i, yumi_i,
    output ready_o, rkey_addr_o, rkey_decr_o, rk_v_o, rk_idx_o, rk_o, v_o, data_o
  );

  modport master (
    output v_i, mode_i, data_i, rkey_i, yumi_i,
    input  ready_o, rkey_addr_o, rkey_decr_o, rk_v_o, rk_idx_o, rk_o, v_o, data_o
  );

endinterface

// File: rtl/sm4_round_engine_round_comb.sv
// rtl/sm4_round_engine_round_comb.sv - one combinational SM4 round
// X4 = X0 ^ T(X1^X2^X3^rk); key mode selects L' instead of L.
module sm4_round_engine_round_comb
  import sm4_round_engine_pkg::*;
(
  input  logic [127:0] i_state,
  input  logic [31:0]  i_rk,
  input  logic         i_key_mode,
  output logic [127:0] o_state,
  output logic [31:0]  o_word
);

  logic [31:0] w_x0, w_x1, w_x2, w_x3;
  logic [31:0] w_fold;
  logic [31:0] w_tau;
  logic [31:0] w_lin;

  assign w_x0   = i_state[127:96];
  assign w_x1   = i_state[95:64];
  assign w_x2   = i_state[63:32];
  assign w_x3   = i_state[31:0];
  assign w_fold = w_x1 ^ w_x2 ^ w_x3 ^ i_rk;

  for (genvar g = 0; g < group_size_p; g++) begin : g_sbox
    assign w_tau[byte_width_p*g +: byte_width_p] = sbox(w_fold[byte_width_p*g +: byte_width_p]);
  end

  assign w_lin   = i_key_mode ? l_key(w_tau) : l_enc(w_tau);
  assign o_word  = w_x0 ^ w_lin;
  assign o_state = {w_x1, w_x2, w_x3, o_word};

endmodule

// File: rtl/sm4_round_engine.sv
// rtl/sm4_round_engine.sv - iterative SM4 round engine (key expansion, encrypt, decrypt)
// Runs rounds_per_cycle_p chained rounds per clock until num_rounds_p rounds are done.
module sm4_round_engine
  import sm4_round_engine_pkg::*;
#(
  parameter int rounds_per_cycle_p = 1,
  parameter int num_rounds_p       = 32
) (
  input logic               clk_i,
  input logic               reset_n_i,
  sm4_round_engine_if.slave bus
);

  localparam int rpc_lp = rounds_per_cycle_p;

  if (!rounds_per_cycle_ok(rounds_per_cycle_p)) begin : g_bad_rpc
    $error("sm4_round_engine: rounds_per_cycle_p must be 1, 2, 4 or 8");
  end

  engine_state_e r_fsm;
  engine_state_e w_fsm_nxt;
  sm4_mode_e     r_mode;
  logic [5:0]    r_cnt;
  logic [127:0]  r_x;
  logic [127:0]  r_result;

  logic          w_accept;
  logic          w_active;
  logic          w_key_mode;
  logic [4:0]    w_dec_addr;
  logic [127:0]  w_chain [rpc_lp+1];
  logic [31:0]   w_rk    [rpc_lp];
  logic [word_width_p*rpc_lp-1:0] w_words;

  assign w_accept   = (r_fsm == ST_IDLE) && bus.v_i;
  assign w_active   = (r_cnt < 6'(num_rounds_p));
  assign w_key_mode = (r_mode == MODE_KEY);
  assign w_dec_addr = 5'(num_rounds_p - 1) - r_cnt[4:0];
  assign w_chain[0] = r_x;

  // Key mode feeds CK from the package; the external key store is bypassed.
  for (genvar k = 0; k < rpc_lp; k++) begin : g_round
    logic [4:0] w_idx;
    assign w_idx   = r_cnt[4:0] + 5'(k);
    assign w_rk[k] = w_key_mode ? ck_word(w_idx) : bus.rkey_i[word_width_p*k +: word_width_p];

    sm4_round_engine_round_comb u_round (
      .i_state    (w_chain[k]),
      .i_rk       (w_rk[k]),
      .i_key_mode (w_key_mode),
      .o_state    (w_chain[k+1]),
      .o_word     (w_words[word_width_p*k +: word_width_p])
    );
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_fsm <= ST_IDLE;
    end else begin
      r_fsm <= w_fsm_nxt;
    end
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      ST_IDLE: if (bus.v_i)     w_fsm_nxt = ST_BUSY;
      ST_BUSY: if (!w_active)   w_fsm_nxt = ST_DONE;
      ST_DONE: if (bus.yumi_i)  w_fsm_nxt = ST_IDLE;
      default:                  w_fsm_nxt = ST_IDLE;
    endcase
  end

  // The result register loads in the BUSY cycle that finds the counter saturated.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_mode   <= MODE_ENC;
      r_cnt    <= '0;
      r_x      <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_mode <= decode_mode(bus.mode_i);
      r_cnt  <= '0;
      r_x    <= (decode_mode(bus.mode_i) == MODE_KEY) ? (bus.data_i ^ FK_BLOCK) : bus.data_i;
    end else if (r_fsm == ST_BUSY) begin
      if (w_active) begin
        r_x   <= w_chain[rpc_lp];
        r_cnt <= r_cnt + 6'(rpc_lp);
      end else begin
        r_result <= reverse_words(r_x);
      end
    end
  end

  always_comb begin
    bus.ready_o     = (r_fsm == ST_IDLE);
    bus.v_o         = (r_fsm == ST_DONE);
    bus.rk_v_o      = (r_fsm == ST_BUSY) && w_key_mode && w_active;
    bus.rk_idx_o    = r_cnt[4:0];
    bus.rk_o        = w_words;
    bus.rkey_decr_o = (r_mode == MODE_DEC);
    bus.rkey_addr_o = (r_mode == MODE_DEC) ? w_dec_addr : r_cnt[4:0];
    bus.data_o      = r_result;
  end

endmodule

// File: tb/tb_sm4_round_engine.sv
// tb/tb_sm4_round_engine.sv - directed bench for the SM4 round engine at R=1, 4 and 8
// A bench-side key store, filled from the key-expansion run, serves rkey_i.
module tb_sm4_round_engine;

  localparam logic [127:0] MK = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] CT = 128'h681edf34d206965e86b3e94f536e4246;

  logic        clk;
  logic        rst_n;
  logic [31:0] ks [32];
  int          n_tests;
  int          n_fail;

  sm4_round_engine_if #(.rounds_per_cycle_p(1)) if1 ();
  sm4_round_engine_if #(.rounds_per_cycle_p(4)) if4 ();
  sm4_round_engine_if #(.rounds_per_cycle_p(8)) if8 ();

  sm4_round_engine #(.rounds_per_cycle_p(1), .num_rounds_p(32)) dut1 (.clk_i(clk), .reset_n_i(rst_n), .bus(if1.slave));
  sm4_round_engine #(.rounds_per_cycle_p(4), .num_rounds_p(32)) dut4 (.clk_i(clk), .reset_n_i(rst_n), .bus(if4.slave));
  sm4_round_engine #(.rounds_per_cycle_p(8), .num_rounds_p(32)) dut8 (.clk_i(clk), .reset_n_i(rst_n), .bus(if8.slave));

  for (genvar k = 0; k < 1; k++) begin : g_ks1
    assign if1.rkey_i[32*k +: 32] = if1.rkey_decr_o ? ks[if1.rkey_addr_o - 5'(k)] : ks[if1.rkey_addr_o + 5'(k)];
  end
  for (genvar k = 0; k < 4; k++) begin : g_ks4
    assign if4.rkey_i[32*k +: 32] = if4.rkey_decr_o ? ks[if4.rkey_addr_o - 5'(k)] : ks[if4.rkey_addr_o + 5'(k)];
  end
  for (genvar k = 0; k < 8; k++) begin : g_ks8
    assign if8.rkey_i[32*k +: 32] = if8.rkey_decr_o ? ks[if8.rkey_addr_o - 5'(k)] : ks[if8.rkey_addr_o + 5'(k)];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int lat;
    int nrk;
    int bad;
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 32; i++) ks[i] = '0;
    rst_n = 1'b0;
    if1.v_i = 0; if1.mode_i = 0; if1.data_i = '0; if1.yumi_i = 0;
    if4.v_i = 0; if4.mode_i = 0; if4.data_i = '0; if4.yumi_i = 0;
    if8.v_i = 0; if8.mode_i = 0; if8.data_i = '0; if8.yumi_i = 0;
    tick();
    tick();

    chk("rst_ready1", 128'(if1.ready_o), 128'd1);
    chk("rst_v1",     128'(if1.v_o),     128'd0);
    chk("rst_rkv1",   128'(if1.rk_v_o),  128'd0);
    chk("rst_data1",  if1.data_o,        128'd0);
    chk("rst_ready4", 128'(if4.ready_o), 128'd1);
    chk("rst_v4",     128'(if4.v_o),     128'd0);
    chk("rst_ready8", 128'(if8.ready_o), 128'd1);
    chk("rst_data8",  if8.data_o,        128'd0);
    rst_n = 1'b1;

    // R=1 key expansion: fills the bench key store.
    if1.mode_i = 2'd0; if1.data_i = MK; if1.v_i = 1;
    tick();
    if1.v_i = 0;
    lat = 0; nrk = 0; bad = 0;
    while (!if1.v_o && lat < 60) begin
      if (if1.rk_v_o) begin
        if (if1.rk_idx_o != 5'(nrk) || lat != nrk) bad++;
        ks[if1.rk_idx_o] = if1.rk_o;
        nrk++;
      end
      tick();
      lat++;
    end
    chk("key1_latency",   128'(lat), 128'd33);
    chk("key1_rk_count",  128'(nrk), 128'd32);
    chk("key1_rk_seq",    128'(bad), 128'd0);
    chk("key1_rk0",       128'(ks[0]),  128'hf12186f9);
    chk("key1_rk31",      128'(ks[31]), 128'h9124a012);
    chk("key1_data_word0", 128'(if1.data_o[127:96]), 128'h9124a012);
    chk("key1_rkv_done",  128'(if1.rk_v_o), 128'd0);
    if1.yumi_i = 1;
    tick();
    if1.yumi_i = 0;
    chk("key1_ready_after_yumi", 128'(if1.ready_o), 128'd1);

    // R=1 encrypt of the standard vector.
    if1.mode_i = 2'd1; if1.data_i = MK; if1.v_i = 1;
    tick();
    if1.v_i = 0;
    lat = 0; bad = 0;
    while (!if1.v_o && lat < 60) begin
      if (if1.rk_v_o || if1.rkey_decr_o || if1.rkey_addr_o != 5'(lat)) bad++;
      tick();
      lat++;
    end
    chk("enc1_latency", 128'(lat), 128'd33);
    chk("enc1_data",    if1.data_o, CT);
    chk("enc1_addr_rkv", 128'(bad > 1), 128'd0);
    if1.yumi_i = 1;
    tick();
    if1.yumi_i = 0;

    // R=4 decrypt; then hold the result for 5 cycles.
    if4.mode_i = 2'd2; if4.data_i = CT; if4.v_i = 1;
    tick();
    if4.v_i = 0;
    lat = 0; bad = 0;
    while (!if4.v_o && lat < 40) begin
      if (lat < 8 && (if4.rkey_addr_o != 5'(31 - 4 * lat) || !if4.rkey_decr_o)) bad++;
      tick();
      lat++;
    end
    chk("dec4_latency", 128'(lat), 128'd9);
    chk("dec4_data",    if4.data_o, MK);
    chk("dec4_addr_seq", 128'(bad), 128'd0);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin if4.v_i = 1; if4.mode_i = 2'd1; end
      tick();
      if4.v_i = 0;
      if (!(if4.v_o === 1'b1 && if4.ready_o === 1'b0 && if4.data_o === MK)) bad++;
    end
    chk("hold_stable", 128'(bad), 128'd0);
    if4.yumi_i = 1;
    tick();
    if4.yumi_i = 0;
    chk("yumi_ready", 128'(if4.ready_o), 128'd1);
    chk("yumi_v",     128'(if4.v_o),     128'd0);
    tick();
    chk("no_queued_req", 128'(if4.ready_o), 128'd1);

    // Reset in the middle of an R=1 encrypt at r=16.
    if1.mode_i = 2'd1; if1.data_i = 128'hdeadbeef; if1.v_i = 1;
    tick();
    if1.v_i = 0;
    for (int i = 0; i < 16; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_ready", 128'(if1.ready_o), 128'd1);
    chk("midrst_v",     128'(if1.v_o),     128'd0);
    chk("midrst_rkv",   128'(if1.rk_v_o),  128'd0);
    chk("midrst_data",  if1.data_o,        128'd0);
    if1.mode_i = 2'd1; if1.data_i = MK; if1.v_i = 1;
    tick();
    if1.v_i = 0;
    lat = 0;
    while (!if1.v_o && lat < 60) begin
      tick();
      lat++;
    end
    chk("midrst_enc_latency", 128'(lat), 128'd33);
    chk("midrst_enc_data",    if1.data_o, CT);
    if1.yumi_i = 1;
    tick();
    if1.yumi_i = 0;

    // R=8 with the illegal mode value 3, which runs as encrypt.
    if8.mode_i = 2'd3; if8.data_i = MK; if8.v_i = 1;
    tick();
    if8.v_i = 0;
    lat = 0;
    while (!if8.v_o && lat < 20) begin
      tick();
      lat++;
    end
    chk("enc8_latency", 128'(lat), 128'd5);
    chk("enc8_data",    if8.data_o, CT);
    if8.yumi_i = 1;
    tick();
    if8.yumi_i = 0;

    // R=8 key expansion: 8 keys per cycle for 4 cycles.
    if8.mode_i = 2'd0; if8.data_i = MK; if8.v_i = 1;
    tick();
    if8.v_i = 0;
    lat = 0; nrk = 0;
    while (!if8.v_o && lat < 20) begin
      if (if8.rk_v_o) begin
        if (lat == 0) chk("key8_rk0", 128'(if8.rk_o[31:0]), 128'hf12186f9);
        if (lat == 3) chk("key8_rk31", 128'(if8.rk_o[255:224]), 128'h9124a012);
        nrk++;
      end
      tick();
      lat++;
    end
    chk("key8_rkv_cycles", 128'(nrk), 128'd4);
    chk("key8_latency",    128'(lat), 128'd5);
    if8.yumi_i = 1;
    tick();
    if8.yumi_i = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
